// File: rtl/rx_deserializer.sv
// UART receive deserializer: synchronizes and oversamples the RX line, majority-votes each bit,
// and reports each frame as a good word, a parity error and/or a stop-bit error.
module rx_deserializer #(
    parameter int WIDTH    = 8,
    parameter int PRESCALE = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_rx_in,
    input  logic             i_par_en,
    input  logic             i_par_typ,
    output logic [WIDTH-1:0] o_data,
    output logic             o_data_valid,
    output logic             o_par_err,
    output logic             o_stp_err,
    output logic             o_busy
);

    localparam int CW = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
    localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_EDGE  = CW'(PRESCALE - 1);
    localparam logic [CW-1:0] SAMPLE_LO  = CW'(PRESCALE / 2 - 1);
    localparam logic [CW-1:0] SAMPLE_MID = CW'(PRESCALE / 2);
    localparam logic [CW-1:0] SAMPLE_HI  = CW'(PRESCALE / 2 + 1);
    localparam logic [BW-1:0] LAST_BIT   = BW'(WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    function automatic logic majority3(input logic [2:0] v);
        majority3 = (v[0] & v[1]) | (v[1] & v[2]) | (v[0] & v[2]);
    endfunction

    function automatic logic expected_parity(input logic [WIDTH-1:0] data, input logic odd);
        expected_parity = odd ? ~(^data) : (^data);
    endfunction

    state_t           state_r;
    logic [1:0]       sync_r;
    logic [CW-1:0]    edge_cnt_r;
    logic [BW-1:0]    bit_cnt_r;
    logic [2:0]       vote_r;
    logic [WIDTH-1:0] shift_r;
    logic             par_en_r;
    logic             par_typ_r;
    logic             par_mis_r;

    logic             rx_s;
    logic             bit_end_s;
    logic             sample_s;
    logic [2:0]       votes_s;
    logic             voted_s;

    assign rx_s      = sync_r[1];
    assign bit_end_s = (edge_cnt_r == LAST_EDGE);
    assign sample_s  = (edge_cnt_r == SAMPLE_LO) || (edge_cnt_r == SAMPLE_MID) ||
                       (edge_cnt_r == SAMPLE_HI);
    assign voted_s   = majority3(votes_s);

    // Vote set seen at bit end; the last sample can coincide with the bit end when PRESCALE is 4.
    always_comb begin
        votes_s = vote_r;
        if (edge_cnt_r == SAMPLE_HI) begin
            votes_s = {vote_r[1:0], rx_s};
        end else begin
            votes_s = vote_r;
        end
    end

    // Two-flop synchronizer for the asynchronous serial line, idling high.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sync_r <= 2'b11;
        end else begin
            sync_r <= {sync_r[0], i_rx_in};
        end
    end

    // Frame FSM with bit timing, voting, shifting and registered result pulses.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_r      <= IDLE;
            edge_cnt_r   <= '0;
            bit_cnt_r    <= '0;
            vote_r       <= 3'b111;
            shift_r      <= '0;
            par_en_r     <= 1'b0;
            par_typ_r    <= 1'b0;
            par_mis_r    <= 1'b0;
            o_data       <= '0;
            o_data_valid <= 1'b0;
            o_par_err    <= 1'b0;
            o_stp_err    <= 1'b0;
            o_busy       <= 1'b0;
        end else begin
            o_data_valid <= 1'b0;
            o_par_err    <= 1'b0;
            o_stp_err    <= 1'b0;
            if (state_r != IDLE) begin
                edge_cnt_r <= bit_end_s ? '0 : edge_cnt_r + CW'(1);
                if (sample_s) begin
                    vote_r <= {vote_r[1:0], rx_s};
                end
            end
            case (state_r)
                IDLE: begin
                    // The detection cycle is edge 0 of the start bit, so START begins at edge 1.
                    if (!rx_s) begin
                        state_r    <= START;
                        o_busy     <= 1'b1;
                        edge_cnt_r <= CW'(1);
                        par_en_r   <= i_par_en;
                        par_typ_r  <= i_par_typ;
                        par_mis_r  <= 1'b0;
                    end else begin
                        edge_cnt_r <= '0;
                    end
                end
                START: begin
                    if (bit_end_s) begin
                        if (voted_s) begin
                            state_r <= IDLE;
                            o_busy  <= 1'b0;
                        end else begin
                            state_r   <= DATA;
                            bit_cnt_r <= '0;
                        end
                    end
                end
                DATA: begin
                    if (bit_end_s) begin
                        shift_r[bit_cnt_r] <= voted_s;
                        if (bit_cnt_r == LAST_BIT) begin
                            state_r <= par_en_r ? PARITY : STOP;
                        end else begin
                            bit_cnt_r <= bit_cnt_r + BW'(1);
                        end
                    end
                end
                PARITY: begin
                    if (bit_end_s) begin
                        par_mis_r <= (voted_s != expected_parity(shift_r, par_typ_r));
                        state_r   <= STOP;
                    end
                end
                STOP: begin
                    if (bit_end_s) begin
                        state_r <= IDLE;
                        o_busy  <= 1'b0;
                        if (voted_s && !par_mis_r) begin
                            o_data       <= shift_r;
                            o_data_valid <= 1'b1;
                        end else begin
                            o_par_err <= par_mis_r;
                            o_stp_err <= ~voted_s;
                        end
                    end
                end
                default: begin
                    state_r <= IDLE;
                    o_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
